// File: rtl/cop_issue_pkg.sv
// Shared decode constants and instruction decoder for the integer front-end.
package cop_issue_pkg;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_COP1  = 6'h11;
  localparam logic [4:0] FMT_MF   = 5'd0;
  localparam logic [4:0] FMT_MT   = 5'd4;
  localparam int OP_LSB  = 26;
  localparam int FMT_LSB = 21;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;

  typedef struct packed {
    logic        lui;
    logic        ori;
    logic        addiu;
    logic        cop1;
    logic        mtc1;
    logic        mfc1;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t       d;
    logic [5:0] op;
    logic [4:0] fmt;
    op      = w[OP_LSB +: 6];
    fmt     = w[FMT_LSB +: 5];
    d.lui   = (op == OP_LUI);
    d.ori   = (op == OP_ORI);
    d.addiu = (op == OP_ADDIU);
    d.cop1  = (op == OP_COP1);
    d.mtc1  = d.cop1 && (fmt == FMT_MT) && (w[10:0] == 11'd0);
    d.mfc1  = d.cop1 && (fmt == FMT_MF) && (w[10:0] == 11'd0);
    d.rs    = w[RS_LSB +: 5];
    d.rt    = w[RT_LSB +: 5];
    d.imm   = w[15:0];
    return d;
  endfunction
endpackage

// File: rtl/cop_dest_fifo.sv
// In-order FIFO of destination register indices for outstanding MFC1 results.
module cop_dest_fifo
  import cop_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_idx, wr_idx;
  logic [AW:0]             cnt;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] i);
    return (i == AW'(DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rd_idx <= '0;
      wr_idx <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= inc(wr_idx);
      end
      if (pop) rd_idx <= inc(rd_idx);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/cop_issue_core.sv
// Integer front-end: PC sequencing, GPR file, LUI/ORI/ADDIU and COP1 issue
// with a scoreboard guarding registers awaiting MFC1 results.
module cop_issue_core
  import cop_issue_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              NREG      = 32,
  parameter int              MFC_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter bit              R0_ZERO   = 1'b1
) (
  input  logic            cpu_clock,
  input  logic            cpu_reset_b,
  output logic            ins_fetch_req,
  output logic [XLEN-1:0] ins_pc,
  input  logic [31:0]     instruction,
  input  logic            cop_hold,
  output logic [31:0]     cop_inst,
  output logic            cop_inst_valid,
  output logic [XLEN-1:0] gpr_to_cop,
  input  logic [XLEN-1:0] gpr_from_cop,
  input  logic            gpr_from_cop_valid,
  output logic            err_spurious
);
  localparam int NW = (NREG > 1) ? $clog2(NREG) : 1;

  dec_t                      d;
  logic [NW-1:0]             rs, rt, head;
  logic [NREG-1:0][XLEN-1:0] gpr;
  logic [NREG-1:0]           sb, sb_nxt;
  logic [XLEN-1:0]           pc, alu;
  logic                      alu_we, haz, stall, consume, push, ret, full, empty;

  function automatic logic wr_ok(input logic [NW-1:0] i);
    return !(R0_ZERO && (i == '0));
  endfunction

  assign d      = decode(instruction);
  assign rs     = d.rs[NW-1:0];
  assign rt     = d.rt[NW-1:0];
  assign alu_we = d.lui | d.ori | d.addiu;

  assign haz   = ((d.ori | d.addiu) & sb[rs])
               | ((d.mtc1 | alu_we | d.mfc1) & sb[rt]);
  assign stall = haz | (d.cop1 & cop_hold) | (d.mfc1 & full);

  // Nothing issues to the FPU while reset is asserted.
  assign consume        = ~stall & cpu_reset_b;
  assign ins_fetch_req  = ~stall;
  assign ins_pc         = pc;
  assign cop_inst_valid = d.cop1 & consume;
  assign cop_inst       = cop_inst_valid ? instruction : '0;
  assign gpr_to_cop     = gpr[rt];
  assign push           = d.mfc1 & consume;
  assign ret            = gpr_from_cop_valid & ~empty;

  always_comb begin
    alu = '0;
    if (d.lui)        alu = XLEN'({d.imm, 16'h0000});
    else if (d.ori)   alu = gpr[rs] | XLEN'(d.imm);
    else if (d.addiu) alu = gpr[rs] + XLEN'($signed(d.imm));
  end

  // Return clears before issue sets, so a same-register pair ends set.
  always_comb begin
    sb_nxt = sb;
    if (ret)  sb_nxt[head] = 1'b0;
    if (push) sb_nxt[rt]   = 1'b1;
  end

  always_ff @(posedge cpu_clock) begin
    if (!cpu_reset_b) begin
      pc           <= RESET_PC;
      gpr          <= '0;
      sb           <= '0;
      err_spurious <= 1'b0;
    end else begin
      sb <= sb_nxt;
      if (ret && wr_ok(head)) gpr[head] <= gpr_from_cop;
      if (!stall) begin
        pc <= pc + XLEN'(4);
        if (alu_we && wr_ok(rt)) gpr[rt] <= alu;
      end
      if (gpr_from_cop_valid && empty) err_spurious <= 1'b1;
    end
  end

  cop_dest_fifo #(
    .DEPTH (MFC_DEPTH),
    .W     (NW)
  ) u_fifo (
    .clk       (cpu_clock),
    .rst_b     (cpu_reset_b),
    .push      (push),
    .push_data (rt),
    .pop       (ret),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );
endmodule

// File: tb/tb_cop_issue_core.sv
// Directed plus random bench; reference is an ISA-level model with a queue of
// pending MFC1 destinations.
module tb_cop_issue_core;
  localparam int XLEN      = 32;
  localparam int MFC_DEPTH = 4;

  logic            cpu_clock = 1'b0;
  logic            cpu_reset_b = 1'b0;
  logic            ins_fetch_req;
  logic [XLEN-1:0] ins_pc;
  logic [31:0]     instruction = '0;
  logic            cop_hold = 1'b0;
  logic [31:0]     cop_inst;
  logic            cop_inst_valid;
  logic [XLEN-1:0] gpr_to_cop;
  logic [XLEN-1:0] gpr_from_cop = '0;
  logic            gpr_from_cop_valid = 1'b0;
  logic            err_spurious;

  int n_chk = 0;
  int n_err = 0;

  logic [XLEN-1:0] m_gpr [32];
  logic [XLEN-1:0] m_pc;
  bit              m_err;
  int              pend[$];

  logic            last_fetch, last_err;
  logic [XLEN-1:0] last_pc, last_to_cop;

  always #5 cpu_clock = ~cpu_clock;

  cop_issue_core #(
    .XLEN(XLEN), .NREG(32), .MFC_DEPTH(MFC_DEPTH), .RESET_PC('0), .R0_ZERO(1'b1)
  ) dut (
    .cpu_clock(cpu_clock), .cpu_reset_b(cpu_reset_b), .ins_fetch_req(ins_fetch_req),
    .ins_pc(ins_pc), .instruction(instruction), .cop_hold(cop_hold),
    .cop_inst(cop_inst), .cop_inst_valid(cop_inst_valid), .gpr_to_cop(gpr_to_cop),
    .gpr_from_cop(gpr_from_cop), .gpr_from_cop_valid(gpr_from_cop_valid),
    .err_spurious(err_spurious)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit busy(input int r);
    foreach (pend[i]) if (pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] lui(input int rt, input logic [15:0] imm);
    return {6'h0F, 5'd0, 5'(rt), imm};
  endfunction
  function automatic logic [31:0] ori(input int rt, input int rs, input logic [15:0] imm);
    return {6'h0D, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] addiu(input int rt, input int rs, input logic [15:0] imm);
    return {6'h09, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] mtc1(input int rt);
    return {6'h11, 5'd4, 5'(rt), 5'd3, 11'd0};
  endfunction
  function automatic logic [31:0] mfc1(input int rt);
    return {6'h11, 5'd0, 5'(rt), 5'd9, 11'd0};
  endfunction

  function automatic logic [31:0] rand_ins();
    int          rt, rs;
    logic [15:0] imm;
    logic [31:0] r;
    rt  = $urandom_range(7);
    rs  = $urandom_range(7);
    imm = 16'($urandom);
    r   = $urandom;
    case ($urandom_range(9))
      0:       return lui(rt, imm);
      1:       return ori(rt, rs, imm);
      2:       return addiu(rt, rs, imm);
      3, 4:    return {6'h11, 5'd4, 5'(rt), r[15:11], 11'd0};
      5, 6:    return {6'h11, 5'd0, 5'(rt), r[15:11], 11'd0};
      7:       return {6'h11, 5'h10, r[20:0]};
      8:       return {6'h23, r[25:0]};
      default: return {6'h11, 5'd4, 5'(rt), 5'd0, r[10:0] | 11'd1};
    endcase
  endfunction

  // One cycle: drive, compare combinational outputs with the model, advance model.
  task automatic step(input logic [31:0] ins, input bit hold, input bit rv,
                      input logic [XLEN-1:0] rdat, output bit took);
    logic [5:0]      op;
    logic [4:0]      rs, rt;
    logic [15:0]     imm;
    bit              is_lui, is_ori, is_addiu, is_cop, is_mt, is_mf, stall;
    logic [XLEN-1:0] res;
    int              h;
    @(negedge cpu_clock);
    cpu_reset_b = 1'b1;
    instruction = ins;
    cop_hold = hold;
    gpr_from_cop_valid = rv;
    gpr_from_cop = rdat;
    #1;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; imm = ins[15:0];
    is_lui = (op == 6'h0F); is_ori = (op == 6'h0D); is_addiu = (op == 6'h09);
    is_cop = (op == 6'h11);
    is_mt  = is_cop && rs == 5'd4 && ins[10:0] == 11'd0;
    is_mf  = is_cop && rs == 5'd0 && ins[10:0] == 11'd0;
    stall  = ((is_ori || is_addiu) && busy(rs))
          || ((is_mt || is_lui || is_ori || is_addiu || is_mf) && busy(rt))
          || (is_cop && hold)
          || (is_mf && pend.size() == MFC_DEPTH);
    last_fetch = ins_fetch_req; last_pc = ins_pc; last_err = err_spurious;
    last_to_cop = gpr_to_cop;
    chk("pc", ins_pc, m_pc);
    chk("fetch", ins_fetch_req, !stall);
    chk("cop_valid", cop_inst_valid, is_cop && !stall);
    chk("err", err_spurious, m_err);
    if (is_cop && !stall) chk("cop_inst", cop_inst, ins);
    if (is_mt && !stall) chk("to_cop", gpr_to_cop, m_gpr[rt]);
    res = '0;
    if (is_lui)   res = {imm, 16'h0000};
    if (is_ori)   res = m_gpr[rs] | {16'h0000, imm};
    if (is_addiu) res = m_gpr[rs] + {{16{imm[15]}}, imm};
    if (rv) begin
      if (pend.size() != 0) begin
        h = pend.pop_front();
        if (h != 0) m_gpr[h] = rdat;
      end else m_err = 1'b1;
    end
    if (!stall) begin
      if ((is_lui || is_ori || is_addiu) && rt != 0) m_gpr[rt] = res;
      if (is_mf) pend.push_back(int'(rt));
      m_pc = m_pc + 4;
    end
    took = !stall;
  endtask

  task automatic issue(input logic [31:0] ins);
    bit took = 1'b0;
    for (int i = 0; i < 64 && !took; i++) step(ins, 1'b0, 1'b0, '0, took);
    if (!took) chk("issue_timeout", last_fetch, 1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge cpu_clock);
      cpu_reset_b = 1'b0; instruction = '0; cop_hold = 1'b0;
      gpr_from_cop_valid = 1'b1; gpr_from_cop = $urandom;
    end
    @(posedge cpu_clock); #1;
    m_pc = '0; foreach (m_gpr[i]) m_gpr[i] = '0; pend.delete(); m_err = 1'b0;
    chk("rst_pc", ins_pc, '0);
    chk("rst_err", err_spurious, 0);
    chk("rst_cop_valid", cop_inst_valid, 0);
  endtask

  initial begin
    bit          took;
    logic [31:0] cur;
    do_reset(3);
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 1'b0, 1'b0, '0, took);
      chk("boot_pc", last_pc, XLEN'(4 * i));
    end

    issue(lui(1, 16'h1234));
    issue(ori(2, 1, 16'h5678));
    issue(addiu(3, 2, 16'hFFFF));
    issue(mtc1(1)); chk("r1", last_to_cop, 32'h12340000);
    issue(mtc1(2)); chk("r2", last_to_cop, 32'h12345678);
    issue(mtc1(3)); chk("r3", last_to_cop, 32'h12345677);

    issue(lui(5, 16'hDEAD));
    for (int i = 0; i < 3; i++) begin
      step(mtc1(5), 1'b1, 1'b0, '0, took);
      chk("hold_fetch", last_fetch, 0);
      chk("hold_cop_valid", cop_inst_valid, 0);
    end
    step(mtc1(5), 1'b0, 1'b0, '0, took);
    chk("mtc1_fetch", last_fetch, 1);
    chk("mtc1_data", last_to_cop, 32'hDEAD0000);

    issue(mfc1(7));
    for (int i = 0; i < 3; i++) begin
      step(ori(8, 7, 16'h0001), 1'b0, 1'b0, '0, took);
      chk("raw_stall", last_fetch, 0);
    end
    step(ori(8, 7, 16'h0001), 1'b0, 1'b1, 32'hA5A5A5A4, took);
    chk("raw_ret_cycle", last_fetch, 0);
    step(ori(8, 7, 16'h0001), 1'b0, 1'b0, '0, took);
    chk("raw_release", last_fetch, 1);
    issue(mtc1(8)); chk("r8", last_to_cop, 32'hA5A5A5A5);

    for (int r = 1; r <= 4; r++) issue(mfc1(r));
    step(mfc1(5), 1'b0, 1'b0, '0, took);
    chk("full_stall", last_fetch, 0);
    step(mfc1(5), 1'b0, 1'b1, 32'h11, took);
    chk("full_pushpop", last_fetch, 0);
    step(mfc1(5), 1'b0, 1'b0, '0, took);
    chk("full_release", last_fetch, 1);
    for (int v = 2; v <= 5; v++) step(32'h0, 1'b0, 1'b1, XLEN'(32'h11 * v), took);
    for (int r = 1; r <= 5; r++) begin
      issue(mtc1(r)); chk("mfc_order", last_to_cop, XLEN'(32'h11 * r));
    end

    step(32'h0, 1'b0, 1'b1, 32'hFFFF, took);
    step(32'h0, 1'b0, 1'b0, '0, took);
    chk("spur_set", last_err, 1);
    issue(mtc1(1)); chk("spur_no_write", last_to_cop, 32'h11);
    chk("spur_sticky", last_err, 1);

    issue(mfc1(10));
    issue(mfc1(11));
    do_reset(1);
    step(mtc1(10), 1'b0, 1'b0, '0, took);
    chk("rst_sb_fetch", last_fetch, 1);
    chk("rst_gpr", last_to_cop, '0);
    step(ori(12, 11, 16'h0007), 1'b0, 1'b0, '0, took);
    chk("rst_sb_fetch2", last_fetch, 1);

    cur = rand_ins();
    for (int i = 0; i < 3000; i++) begin
      bit hold, rv;
      hold = ($urandom_range(3) == 0);
      rv   = (pend.size() != 0) ? ($urandom_range(2) == 0) : ($urandom_range(199) == 0);
      step(cur, hold, rv, $urandom, took);
      if (took) cur = rand_ins();
    end
    for (int i = 0; i < 64 && pend.size() != 0; i++) step(32'h0, 1'b0, 1'b1, $urandom, took);
    for (int r = 0; r < 8; r++) issue(mtc1(r));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
